reversi_control: RTL and testbench

Control FSM for the reversi game and the counterpart of the game datapath's enable/done handshake. It asserts exactly one datapath enable at a time and holds it until the datapath returns `go`. It branches on `validMove` and `hasTurn`, and turns debounced key levels into single-cycle move and enter events. It sits between the keypad inputs and the datapath, and drives the datapath's enable ports and the VGA `writeEn`.

---
 rtl/reversi_control_if.sv | 51 +++++
 rtl/reversi_control.sv | 152 +++++++++++++++
 tb/tb_reversi_control.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/reversi_control_if.sv
// Keypad and datapath handshake bundle for the reversi game controller.
// The master modport is the controller side; the slave modport is the keypad/datapath side.
interface reversi_control_if #(
  parameter int STATE_W = 5
);
  logic key_enter;
  logic key_up;
  logic key_down;
  logic key_left;
  logic key_right;
  logic go;
  logic validMove;
  logic hasTurn;

  logic writeEn;
  logic drawBoardEn;
  logic drawInitialPiecesEn;
  logic moveHighlightEn;
  logic checkIfValidMoveEn;
  logic placeEn;
  logic flipEn;
  logic scoreManagerEn;
  logic determineHasTurnEn;
  logic determineOpponent;
  logic determineCurrent;
  logic TurnManagerEn;
  logic removeHighlightEn;
  logic enterEn;
  logic moveUpEn;
  logic moveDownEn;
  logic moveLeftEn;
  logic moveRightEn;
  logic [STATE_W-1:0] state_dbg;
  logic game_over;

  modport master (
    input  key_enter, key_up, key_down, key_left, key_right, go, validMove, hasTurn,
    output writeEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn, checkIfValidMoveEn,
           placeEn, flipEn, scoreManagerEn, determineHasTurnEn, determineOpponent,
           determineCurrent, TurnManagerEn, removeHighlightEn, enterEn, moveUpEn,
           moveDownEn, moveLeftEn, moveRightEn, state_dbg, game_over
  );

  modport slave (
    output key_enter, key_up, key_down, key_left, key_right, go, validMove, hasTurn,
    input  writeEn, drawBoardEn, drawInitialPiecesEn, moveHighlightEn, checkIfValidMoveEn,
           placeEn, flipEn, scoreManagerEn, determineHasTurnEn, determineOpponent,
           determineCurrent, TurnManagerEn, removeHighlightEn, enterEn, moveUpEn,
           moveDownEn, moveLeftEn, moveRightEn, state_dbg, game_over
  );
endinterface

// File: rtl/reversi_control.sv
// Reversi control FSM: sequences datapath operations via enable/go and turns key levels into events.
// Optional busy-state watchdog enabled by defining CTRL_WATCHDOG_EN.
module reversi_control #(
  parameter int WDOG_CYCLES = 20000,
  parameter int STATE_W     = 5
) (
  input  logic              clk,
  input  logic              resetn,
  reversi_control_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,  S_BOARD = 4'd1,  S_INIT    = 4'd2,  S_HL      = 4'd3,
    S_IDLE  = 4'd4,  S_MOVE  = 4'd5,  S_CHECK   = 4'd6,  S_PLACE   = 4'd7,
    S_FLIP  = 4'd8,  S_SCORE = 4'd9,  S_DET_OPP = 4'd10, S_DET_CUR = 4'd11,
    S_TURN  = 4'd12, S_UNHL  = 4'd13, S_OVER    = 4'd14, S_ERR     = 4'd15
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  keyLvl, keyPrev_q, keyEdge;
  logic [3:0]  dirPick;
  logic        enterHit;
  logic [13:0] ops_q;
  logic        enterEn_q;
  logic [3:0]  moveEn_q;

  // Ops bit order: {writeEn, drawBoard, drawInit, moveHL, check, place, flip, score,
  //                 detHasTurn, detOpp, detCur, turn, removeHL, gameOver}
  function automatic logic [13:0] decodeOps(input state_t s);
    case (s)
      S_BOARD:   decodeOps = 14'b11000000000000;
      S_INIT:    decodeOps = 14'b10100000000000;
      S_HL:      decodeOps = 14'b10010000000000;
      S_CHECK:   decodeOps = 14'b00001000000000;
      S_PLACE:   decodeOps = 14'b10000100000000;
      S_FLIP:    decodeOps = 14'b10000010000000;
      S_SCORE:   decodeOps = 14'b00000001000000;
      S_DET_OPP: decodeOps = 14'b00000000110000;
      S_DET_CUR: decodeOps = 14'b00000000101000;
      S_TURN:    decodeOps = 14'b00000000000100;
      S_UNHL:    decodeOps = 14'b10000000000010;
      S_OVER:    decodeOps = 14'b00000000000001;
      S_ERR:     decodeOps = 14'b00000000000001;
      default:   decodeOps = 14'b00000000000000;
    endcase
  endfunction

  assign keyLvl  = {bus.key_enter, bus.key_up, bus.key_down, bus.key_left, bus.key_right};
  assign keyEdge = keyLvl & ~keyPrev_q;
  assign dirPick = keyEdge[3] ? 4'b1000 :
                   keyEdge[2] ? 4'b0100 :
                   keyEdge[1] ? 4'b0010 : 4'b0001;

`ifdef CTRL_WATCHDOG_EN
  logic [15:0] wdog_q;
  logic        busy;

  assign busy = (state_q == S_BOARD) || (state_q == S_INIT) || (state_q == S_HL) ||
                (state_q == S_CHECK) || (state_q == S_PLACE) || (state_q == S_FLIP) ||
                (state_q == S_SCORE) || (state_q == S_DET_OPP) || (state_q == S_DET_CUR) ||
                (state_q == S_TURN) || (state_q == S_UNHL);
`endif

  always_comb begin
    state_d  = state_q;
    enterHit = 1'b0;
    case (state_q)
      S_RESET:   state_d = S_BOARD;
      S_BOARD:   if (bus.go) state_d = S_INIT;
      S_INIT:    if (bus.go) state_d = S_HL;
      S_HL:      if (bus.go) state_d = S_IDLE;
      S_IDLE: begin
        if (keyEdge[4]) begin
          state_d  = S_CHECK;
          enterHit = 1'b1;
        end else if (|keyEdge[3:0]) begin
          state_d = S_MOVE;
        end
      end
      S_MOVE:    state_d = S_HL;
      S_CHECK:   if (bus.go) state_d = bus.validMove ? S_PLACE : S_IDLE;
      S_PLACE:   if (bus.go) state_d = S_FLIP;
      S_FLIP:    if (bus.go) state_d = S_SCORE;
      S_SCORE:   if (bus.go) state_d = S_DET_OPP;
      S_DET_OPP: if (bus.go) state_d = bus.hasTurn ? S_TURN : S_DET_CUR;
      S_DET_CUR: if (bus.go) state_d = bus.hasTurn ? S_HL : S_UNHL;
      S_TURN:    if (bus.go) state_d = S_HL;
      S_UNHL:    if (bus.go) state_d = S_OVER;
      S_OVER: begin
        if (keyEdge[4]) begin
          state_d  = S_BOARD;
          enterHit = 1'b1;
        end
      end
      S_ERR:     state_d = S_ERR;
      default:   state_d = S_RESET;
    endcase
`ifdef CTRL_WATCHDOG_EN
    if (busy && !bus.go && (wdog_q == 16'(WDOG_CYCLES - 1)))
      state_d = S_ERR;
`endif
  end

  // Outputs are registered from the next state so they line up with state_q;
  // key event pulses appear on the first cycle of the state that consumed them.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q   <= S_RESET;
      keyPrev_q <= 5'b0;
      ops_q     <= 14'b0;
      enterEn_q <= 1'b0;
      moveEn_q  <= 4'b0;
    end else begin
      state_q   <= state_d;
      keyPrev_q <= keyLvl;
      ops_q     <= decodeOps(state_d);
      enterEn_q <= enterHit;
      moveEn_q  <= (state_q == S_IDLE && state_d == S_MOVE) ? dirPick : 4'b0;
    end
  end

`ifdef CTRL_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (resetn || !busy || (state_d != state_q))
      wdog_q <= 16'd0;
    else
      wdog_q <= wdog_q + 16'd1;
  end
`endif

  assign bus.writeEn             = ops_q[13];
  assign bus.drawBoardEn         = ops_q[12];
  assign bus.drawInitialPiecesEn = ops_q[11];
  assign bus.moveHighlightEn     = ops_q[10];
  assign bus.checkIfValidMoveEn  = ops_q[9];
  assign bus.placeEn             = ops_q[8];
  assign bus.flipEn              = ops_q[7];
  assign bus.scoreManagerEn      = ops_q[6];
  assign bus.determineHasTurnEn  = ops_q[5];
  assign bus.determineOpponent   = ops_q[4];
  assign bus.determineCurrent    = ops_q[3];
  assign bus.TurnManagerEn       = ops_q[2];
  assign bus.removeHighlightEn   = ops_q[1];
  assign bus.game_over           = ops_q[0];
  assign bus.enterEn             = enterEn_q;
  assign bus.moveUpEn            = moveEn_q[3];
  assign bus.moveDownEn          = moveEn_q[2];
  assign bus.moveLeftEn          = moveEn_q[1];
  assign bus.moveRightEn         = moveEn_q[0];
  assign bus.state_dbg           = STATE_W'(state_q);

endmodule

// File: tb/tb_reversi_control.sv
// Table-driven bench for reversi_control: vectors feed a scoreboard queue checked after each edge.
// The watchdog section follows CTRL_WATCHDOG_EN with WDOG_CYCLES set to 100.
module tb_reversi_control;

  typedef struct {
    logic       rst;
    logic       go;
    logic       vm;
    logic       ht;
    logic [4:0] keys;
    logic [4:0] expState;
    logic [4:0] expEvt;
  } vec_t;

  localparam logic [4:0] E = 5'b10000;
  localparam logic [4:0] U = 5'b01000;
  localparam logic [4:0] D = 5'b00100;
  localparam logic [4:0] L = 5'b00010;
  localparam logic [4:0] R = 5'b00001;

  logic clk;
  logic resetn;
  vec_t vecs[$];
  logic [23:0] sbQ[$];
  int compared;
  int mismatched;

  reversi_control_if #(.STATE_W(5)) bus ();

  reversi_control #(.WDOG_CYCLES(100), .STATE_W(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected operation outputs for each state code:
  // {writeEn, drawBoard, drawInit, moveHL, check, place, flip, score,
  //  detHasTurn, detOpp, detCur, turn, removeHL, game_over}
  function automatic logic [13:0] expOps(input logic [4:0] s);
    logic [13:0] o;
    o = '0;
    case (s)
      5'd1:  begin o[13] = 1'b1; o[12] = 1'b1; end
      5'd2:  begin o[13] = 1'b1; o[11] = 1'b1; end
      5'd3:  begin o[13] = 1'b1; o[10] = 1'b1; end
      5'd6:  o[9] = 1'b1;
      5'd7:  begin o[13] = 1'b1; o[8] = 1'b1; end
      5'd8:  begin o[13] = 1'b1; o[7] = 1'b1; end
      5'd9:  o[6] = 1'b1;
      5'd10: begin o[5] = 1'b1; o[4] = 1'b1; end
      5'd11: begin o[5] = 1'b1; o[3] = 1'b1; end
      5'd12: o[2] = 1'b1;
      5'd13: begin o[13] = 1'b1; o[1] = 1'b1; end
      5'd14: o[0] = 1'b1;
      5'd15: o[0] = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic v(input logic rst, input logic go, input logic vm, input logic ht,
                   input logic [4:0] keys, input logic [4:0] s, input logic [4:0] evt);
    vec_t t;
    t.rst = rst; t.go = go; t.vm = vm; t.ht = ht;
    t.keys = keys; t.expState = s; t.expEvt = evt;
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input int idx);
    logic [23:0] exp;
    logic [23:0] act;
    act = {bus.state_dbg, bus.writeEn, bus.drawBoardEn, bus.drawInitialPiecesEn,
           bus.moveHighlightEn, bus.checkIfValidMoveEn, bus.placeEn, bus.flipEn,
           bus.scoreManagerEn, bus.determineHasTurnEn, bus.determineOpponent,
           bus.determineCurrent, bus.TurnManagerEn, bus.removeHighlightEn, bus.game_over,
           bus.enterEn, bus.moveUpEn, bus.moveDownEn, bus.moveLeftEn, bus.moveRightEn};
    compared++;
    if (sbQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL vec%0d: scoreboard empty, got %h", idx, act);
    end else begin
      exp = sbQ.pop_front();
      if (act !== exp) begin
        mismatched++;
        $display("[TB] FAIL vec%0d: got state=%0d out=%b, want state=%0d out=%b",
                 idx, act[23:19], act[18:0], exp[23:19], exp[18:0]);
      end
    end
  endtask

  task automatic applyStimulus(input int idx);
    vec_t t;
    t = vecs[idx];
    resetn        = t.rst;
    bus.go        = t.go;
    bus.validMove = t.vm;
    bus.hasTurn   = t.ht;
    {bus.key_enter, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = t.keys;
    sbQ.push_back({t.expState, expOps(t.expState), t.expEvt});
    @(posedge clk);
    #1;
    checkOutput(idx);
  endtask

  task automatic toIdle();
    v(0, 1, 0, 0, 0, 2, 0);
    v(0, 1, 0, 0, 0, 3, 0);
    v(0, 1, 0, 0, 0, 4, 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    resetn = 1'b1;
    bus.go = 1'b0; bus.validMove = 1'b0; bus.hasTurn = 1'b0;
    {bus.key_enter, bus.key_up, bus.key_down, bus.key_left, bus.key_right} = 5'b0;

    // Reset, then the board draw waits for go indefinitely
    for (int i = 0; i < 3; i++) v(1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 50; i++) v(0, 0, 0, 0, 0, 1, 0);
    v(0, 1, 0, 0, 0, 2, 0);
    v(0, 0, 0, 0, 0, 2, 0);
    v(0, 1, 0, 0, 0, 3, 0);
    v(0, 1, 0, 0, 0, 4, 0);
    v(0, 0, 0, 0, 0, 4, 0);

    // Held right key yields one move event only
    v(0, 0, 0, 0, R, 5, R);
    for (int i = 0; i < 9; i++) v(0, 0, 0, 0, R, 3, 0);
    v(0, 1, 0, 0, R, 4, 0);
    v(0, 0, 0, 0, R, 4, 0);
    v(0, 0, 0, 0, 0, 4, 0);

    // Enter beats up; invalid move returns to idle; go ignored in idle
    v(0, 0, 0, 0, E | U, 6, E);
    v(0, 0, 0, 0, E | U, 6, 0);
    v(0, 1, 0, 0, E | U, 4, 0);
    v(0, 0, 0, 0, E | U, 4, 0);
    v(0, 0, 0, 0, 0, 4, 0);
    v(0, 1, 0, 0, 0, 4, 0);

    // Direction priority
    v(0, 0, 0, 0, U | D | L, 5, U);
    v(0, 0, 0, 0, 0, 3, 0);
    v(0, 1, 0, 0, 0, 4, 0);
    v(0, 0, 0, 0, D | L | R, 5, D);
    v(0, 0, 0, 0, 0, 3, 0);
    v(0, 1, 0, 0, 0, 4, 0);
    v(0, 0, 0, 0, L | R, 5, L);
    v(0, 0, 0, 0, 0, 3, 0);
    v(0, 1, 0, 0, 0, 4, 0);

    // Valid move, opponent stuck, current player moves again
    v(0, 0, 0, 0, E, 6, E);
    v(0, 1, 1, 0, 0, 7, 0);
    v(0, 0, 0, 0, 0, 7, 0);
    v(0, 1, 0, 0, 0, 8, 0);
    v(0, 1, 0, 0, 0, 9, 0);
    v(0, 1, 0, 0, 0, 10, 0);
    v(0, 1, 0, 0, 0, 11, 0);
    v(0, 1, 0, 1, 0, 3, 0);
    v(0, 1, 0, 0, 0, 4, 0);

    // Valid move, opponent has a turn
    v(0, 0, 0, 0, E, 6, E);
    v(0, 1, 1, 0, 0, 7, 0);
    v(0, 1, 0, 0, 0, 8, 0);
    v(0, 1, 0, 0, 0, 9, 0);
    v(0, 1, 0, 0, 0, 10, 0);
    v(0, 1, 0, 1, 0, 12, 0);
    v(0, 0, 0, 0, 0, 12, 0);
    v(0, 1, 0, 0, 0, 3, 0);
    v(0, 1, 0, 0, 0, 4, 0);

    // Nobody can move: game over, then enter starts a new game
    v(0, 0, 0, 0, E, 6, E);
    v(0, 1, 1, 0, 0, 7, 0);
    v(0, 1, 0, 0, 0, 8, 0);
    v(0, 1, 0, 0, 0, 9, 0);
    v(0, 1, 0, 0, 0, 10, 0);
    v(0, 1, 0, 0, 0, 11, 0);
    v(0, 1, 0, 0, 0, 13, 0);
    v(0, 1, 0, 0, 0, 14, 0);
    v(0, 1, 0, 0, 0, 14, 0);
    v(0, 0, 0, 0, U, 14, 0);
    v(0, 0, 0, 0, 0, 14, 0);
    v(0, 0, 0, 0, E, 1, E);
    v(0, 0, 0, 0, 0, 1, 0);

    // An edge seen in a busy state is discarded, not queued
    v(0, 1, 0, 0, 0, 2, 0);
    v(0, 1, 0, 0, 0, 3, 0);
    v(0, 0, 0, 0, R, 3, 0);
    v(0, 1, 0, 0, R, 4, 0);
    v(0, 0, 0, 0, R, 4, 0);
    v(0, 0, 0, 0, 0, 4, 0);

    // Reset during flip aborts at once
    v(0, 0, 0, 0, E, 6, E);
    v(0, 1, 1, 0, 0, 7, 0);
    v(0, 1, 0, 0, 0, 8, 0);
    v(1, 0, 0, 0, 0, 0, 0);
    v(1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 1, 0);
    toIdle();

    // Check state held without go
    v(0, 0, 0, 0, E, 6, E);
`ifdef CTRL_WATCHDOG_EN
    for (int i = 0; i < 99; i++) v(0, 0, 0, 0, 0, 6, 0);
    v(0, 0, 0, 0, 0, 15, 0);
    v(0, 1, 1, 0, E, 15, 0);
    v(0, 0, 0, 0, 0, 15, 0);
    v(1, 0, 0, 0, 0, 0, 0);
    v(0, 0, 0, 0, 0, 1, 0);
`else
    for (int i = 0; i < 150; i++) v(0, 0, 0, 0, 0, 6, 0);
    v(0, 1, 0, 0, 0, 4, 0);
`endif

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) applyStimulus(i);

    if (sbQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: %0d entries left, want 0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
